// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants and types for the CPU control sequencer.
//   - opcode values for the 5-bit opcode field IR[31:27]
//   - step encodings T0..T7 and HALT (4-bit)
//   - IR field bit positions
//   - ctrl_t: bundle of every datapath strobe the sequencer drives
//   - last_step(): final execute step of each opcode
package cpu_ctrl_pkg;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Step encodings
  localparam logic [3:0] T0     = 4'd0;
  localparam logic [3:0] T1     = 4'd1;
  localparam logic [3:0] T2     = 4'd2;
  localparam logic [3:0] T3     = 4'd3;
  localparam logic [3:0] T4     = 4'd4;
  localparam logic [3:0] T5     = 4'd5;
  localparam logic [3:0] T6     = 4'd6;
  localparam logic [3:0] T7     = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  // IR field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef struct packed {
    logic pc_in;
    logic ir_in;
    logic mar_in;
    logic mdr_in;
    logic y_in;
    logic zlow_in;
    logic zhigh_in;
    logic hi_in;
    logic lo_in;
    logic inport_in;
    logic outport_in;
    logic con_in;
    logic pc_out;
    logic mdr_out;
    logic zlow_out;
    logic zhigh_out;
    logic hi_out;
    logic lo_out;
    logic inport_out;
    logic c_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic inc_pc;
    logic md_read;
    logic write_en;
  } ctrl_t;

  // Final step of each instruction; always T3 or later, so it can never
  // collide with a fetch step.
  function automatic logic [3:0] last_step(input logic [4:0] opc);
    logic [3:0] s;
    case (opc)
      OP_LD, OP_ST:                          s = T7;
      OP_DIV, OP_MUL, OP_BR:                 s = T6;
      OP_NEG, OP_NOT, OP_JAL:                s = T4;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI:              s = T5;
      default:                               s = T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// ctrl_step_counter: step register of the control sequencer.
//   clk_i        : clock, rising edge
//   clear_i      : synchronous active-high reset, forces T0
//   opcode_i     : opcode field of the current IR
//   stop_i       : halt request, honoured only on the final step
//   step_o       : current step (T0..T7 or S_HALT)
//   instr_done_o : high on the final step of each instruction
module ctrl_step_counter
  import cpu_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic [4:0] opcode_i,
  input  logic       stop_i,
  output logic [3:0] step_o,
  output logic       instr_done_o
);

  logic [3:0] step_q;
  logic [3:0] step_d;
  logic       is_last;

  // HALT (8) never equals a last step, so is_last is low in HALT.
  assign is_last = (step_q == last_step(opcode_i));

  always_comb begin
    step_d = step_q;
    if (step_q == S_HALT) begin
      step_d = S_HALT;
    end else if (is_last) begin
      step_d = (stop_i || opcode_i == OP_HALT) ? S_HALT : T0;
    end else begin
      step_d = step_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      step_q <= T0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o       = step_q;
  assign instr_done_o = is_last && !clear_i;

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore control sequencer for the CPU datapath.
//   clock, clear      : clock and synchronous active-high reset
//   IR, CON_FF        : instruction register and branch flag from datapath
//   stop              : halt request at the next instruction boundary
//   *in outputs       : register load enables
//   *out outputs      : bus drive selects
//   Gra..BAout        : register-file select/encode controls
//   IncPC/MD_read/Write : PC increment, memory read, memory write
//   run               : high while executing
//   instr_done        : high on the last step of each instruction
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W  = 32,
  parameter int OPC_W = 5
)(
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] IR,
  input  logic            CON_FF,
  input  logic            stop,
  output logic PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin,
  output logic InPortin, OutPortin, CONin,
  output logic PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout,
  output logic Gra, Grb, Grc, Rin, Rout, BAout,
  output logic IncPC, MD_read, Write,
  output logic run,
  output logic instr_done
);

  logic [OPC_W-1:0] opcode;
  logic [3:0]       step;
  logic             done;
  ctrl_t            ctl;
  logic             unused_ir_fields;

  assign opcode = IR[IR_W-1 -: OPC_W];
  // Register fields are decoded by the datapath itself via Gra/Grb/Grc.
  assign unused_ir_fields = ^IR[IR_W-OPC_W-1:0];

  ctrl_step_counter u_step (
    .clk_i        (clock),
    .clear_i      (clear),
    .opcode_i     (opcode),
    .stop_i       (stop),
    .step_o       (step),
    .instr_done_o (done)
  );

  always_comb begin
    ctl = '0;
    case (step)
      T0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.zlow_in = 1'b1; end
      T1: begin ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; ctl.md_read = 1'b1; ctl.mdr_in = 1'b1; end
      T2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
      default: begin
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin
            case (step)
              T3: begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1; end
              T4: begin ctl.c_out = 1'b1; ctl.zlow_in = 1'b1; end
              T5: begin
                ctl.zlow_out = 1'b1;
                if (opcode == OP_LDI) begin
                  ctl.gra = 1'b1; ctl.r_in = 1'b1;
                end else begin
                  ctl.mar_in = 1'b1;
                end
              end
              T6: begin
                ctl.mdr_in = 1'b1;
                // Store loads MDR from the register file, not from memory.
                if (opcode == OP_ST) begin
                  ctl.gra = 1'b1; ctl.r_out = 1'b1;
                end else begin
                  ctl.md_read = 1'b1;
                end
              end
              T7: begin
                if (opcode == OP_ST) begin
                  ctl.write_en = 1'b1;
                end else begin
                  ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step)
              T3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
              T4: begin
                ctl.zlow_in = 1'b1;
                if (opcode >= OP_ADDI) begin
                  ctl.c_out = 1'b1;
                end else begin
                  ctl.grc = 1'b1; ctl.r_out = 1'b1;
                end
              end
              T5: begin ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
              default: ;
            endcase
          end
          OP_DIV, OP_MUL: begin
            case (step)
              T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
              T4: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.zlow_in = 1'b1; ctl.zhigh_in = 1'b1; end
              T5: begin ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1; end
              T6: begin ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (step)
              T3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.zlow_in = 1'b1; end
              T4: begin ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
              default: ;
            endcase
          end
          OP_BR: begin
            case (step)
              T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; end
              T4: begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; end
              T5: begin ctl.c_out = 1'b1; ctl.zlow_in = 1'b1; end
              // Branch target is committed only when the condition holds.
              T6: begin ctl.zlow_out = 1'b1; ctl.pc_in = CON_FF; end
              default: ;
            endcase
          end
          OP_JR: begin
            if (step == T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
          end
          OP_JAL: begin
            case (step)
              T3: begin ctl.pc_out = 1'b1; ctl.grb = 1'b1; ctl.r_in = 1'b1; end
              T4: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
              default: ;
            endcase
          end
          OP_IN: begin
            if (step == T3) begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          end
          OP_OUT: begin
            if (step == T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1; end
          end
          OP_MFHI: begin
            if (step == T3) begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          end
          OP_MFLO: begin
            if (step == T3) begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          end
          default: ;  // nop, halt and undefined opcodes: no strobes
        endcase
      end
    endcase
    // clear silences every strobe immediately, including the cycle before
    // the first clock edge, so an aborted instruction issues nothing more.
    if (clear || step == S_HALT) begin
      ctl = '0;
    end
  end

  assign PCin       = ctl.pc_in;
  assign IRin       = ctl.ir_in;
  assign MARin      = ctl.mar_in;
  assign MDRin      = ctl.mdr_in;
  assign Yin        = ctl.y_in;
  assign Zlowin     = ctl.zlow_in;
  assign Zhighin    = ctl.zhigh_in;
  assign HIin       = ctl.hi_in;
  assign LOin       = ctl.lo_in;
  assign InPortin   = ctl.inport_in;
  assign OutPortin  = ctl.outport_in;
  assign CONin      = ctl.con_in;
  assign PCout      = ctl.pc_out;
  assign MDRout     = ctl.mdr_out;
  assign Zlowout    = ctl.zlow_out;
  assign Zhighout   = ctl.zhigh_out;
  assign HIout      = ctl.hi_out;
  assign LOout      = ctl.lo_out;
  assign InPortout  = ctl.inport_out;
  assign Cout       = ctl.c_out;
  assign Gra        = ctl.gra;
  assign Grb        = ctl.grb;
  assign Grc        = ctl.grc;
  assign Rin        = ctl.r_in;
  assign Rout       = ctl.r_out;
  assign BAout      = ctl.ba_out;
  assign IncPC      = ctl.inc_pc;
  assign MD_read    = ctl.md_read;
  assign Write      = ctl.write_en;
  assign run        = !clear && (step != S_HALT);
  assign instr_done = done;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed plus randomized check of control_unit against
// a microprogram table written as strobe-name strings per step.
module tb_control_unit;

  logic        clock  = 1'b0;
  logic        clear  = 1'b1;
  logic [31:0] IR     = 32'h0;
  logic        CON_FF = 1'b0;
  logic        stop   = 1'b0;

  logic PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin;
  logic InPortin, OutPortin, CONin;
  logic PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic IncPC, MD_read, Write, run, instr_done;

  always #5 clock = ~clock;

  control_unit #(.IR_W(32), .OPC_W(5)) dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
    .InPortin(InPortin), .OutPortin(OutPortin), .CONin(CONin),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .IncPC(IncPC), .MD_read(MD_read), .Write(Write),
    .run(run), .instr_done(instr_done)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Bit k of a strobe vector corresponds to names[k].
  string names [29] = '{"PCin", "IRin", "MARin", "MDRin", "Yin", "Zlowin",
                        "Zhighin", "HIin", "LOin", "InPortin", "OutPortin",
                        "CONin", "PCout", "MDRout", "Zlowout", "Zhighout",
                        "HIout", "LOout", "InPortout", "Cout", "Gra", "Grb",
                        "Grc", "Rin", "Rout", "BAout", "IncPC", "MD_read",
                        "Write"};

  logic [28:0] obs;
  assign obs = {Write, MD_read, IncPC, BAout, Rout, Rin, Grc, Grb, Gra, Cout,
                InPortout, LOout, HIout, Zhighout, Zlowout, MDRout, PCout,
                CONin, OutPortin, InPortin, LOin, HIin, Zhighin, Zlowin, Yin,
                MDRin, MARin, IRin, PCin};

  logic [7:0] drv;
  assign drv = {PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout};

  string exp_q[$];

  function automatic logic [28:0] bits_of(input string s);
    logic [28:0] v;
    string       w;
    bit          found;
    v = '0;
    w = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (w.len() > 0) begin
          found = 1'b0;
          for (int k = 0; k < 29; k++) begin
            if (names[k] == w) begin
              v[k]  = 1'b1;
              found = 1'b1;
            end
          end
          if (!found) $fatal(1, "FAIL model: unknown strobe name %s", w);
        end
        w = "";
      end else begin
        w = {w, s.substr(i, i)};
      end
    end
    return v;
  endfunction

  // Microprogram of one instruction: fetch steps then execute steps.
  task automatic load_ucode(input logic [4:0] opc, input logic con);
    string ex;
    string cur;
    case (opc)
      5'd0:  ex = "Grb BAout Yin|Cout Zlowin|Zlowout MARin|MD_read MDRin|MDRout Gra Rin";
      5'd1:  ex = "Grb BAout Yin|Cout Zlowin|Zlowout Gra Rin";
      5'd2:  ex = "Grb BAout Yin|Cout Zlowin|Zlowout MARin|Gra Rout MDRin|Write";
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11:
             ex = "Grb Rout Yin|Grc Rout Zlowin|Zlowout Gra Rin";
      5'd12, 5'd13, 5'd14:
             ex = "Grb Rout Yin|Cout Zlowin|Zlowout Gra Rin";
      5'd15, 5'd16:
             ex = "Gra Rout Yin|Grb Rout Zlowin Zhighin|Zlowout LOin|Zhighout HIin";
      5'd17, 5'd18:
             ex = "Grb Rout Zlowin|Zlowout Gra Rin";
      5'd19: ex = con ? "Gra Rout CONin|PCout Yin|Cout Zlowin|Zlowout PCin"
                      : "Gra Rout CONin|PCout Yin|Cout Zlowin|Zlowout";
      5'd20: ex = "Gra Rout PCin";
      5'd21: ex = "PCout Grb Rin|Gra Rout PCin";
      5'd22: ex = "InPortout Gra Rin";
      5'd23: ex = "Gra Rout OutPortin";
      5'd24: ex = "HIout Gra Rin";
      5'd25: ex = "LOout Gra Rin";
      default: ex = "";
    endcase
    exp_q.delete();
    exp_q.push_back("PCout MARin IncPC Zlowin");
    exp_q.push_back("Zlowout PCin MD_read MDRin");
    exp_q.push_back("MDRout IRin");
    cur = "";
    for (int i = 0; i < ex.len(); i++) begin
      if (ex[i] == 8'h7C) begin
        exp_q.push_back(cur);
        cur = "";
      end else begin
        cur = {cur, ex.substr(i, i)};
      end
    end
    exp_q.push_back(cur);
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Inputs are already applied (#1 after a rising edge); sample at the
  // falling edge, then move to #1 after the next rising edge.
  task automatic check_cycle(input string tag, input string exp_s,
                             input logic exp_done, input logic exp_run);
    @(negedge clock);
    chk({tag, ":strobes"}, 32'(obs), 32'(bits_of(exp_s)));
    chk({tag, ":done"}, 32'(instr_done), 32'(exp_done));
    chk({tag, ":run"}, 32'(run), 32'(exp_run));
    chk({tag, ":bus"}, 32'($countones(drv) <= 1), 32'd1);
    @(posedge clock);
    #1;
  endtask

  // Entered with the DUT in T0. stop_from >= 0 raises stop from that step
  // on; otherwise rand_stop pulses stop randomly on non-final steps only.
  task automatic run_instr(input logic [31:0] ir, input logic con,
                           input int stop_from, input logic rand_stop);
    logic [4:0] opc;
    int         last;
    opc = ir[31:27];
    load_ucode(opc, con);
    last = exp_q.size() - 1;
    for (int j = 0; j <= last; j++) begin
      if (j == 3) IR = ir;
      CON_FF = (opc == 5'd19 && j == 6) ? con : 1'($urandom_range(0, 1));
      if (stop_from >= 0) stop = (j >= stop_from);
      else stop = (rand_stop && j < last) ? 1'($urandom_range(0, 1)) : 1'b0;
      check_cycle($sformatf("op%0d_T%0d", opc, j), exp_q[j], j == last, 1'b1);
    end
    $display("instr ir=%h opc=%0d con=%0d steps=%0d", ir, opc, con, last + 1);
  endtask

  task automatic expect_halt(input string tag, input int n);
    for (int i = 0; i < n; i++) check_cycle($sformatf("%s_%0d", tag, i), "", 1'b0, 1'b0);
    $display("halt check %s cycles=%0d", tag, n);
  endtask

  initial begin
    logic [4:0] opc;

    // Reset: everything silent while clear is high.
    check_cycle("reset_a", "", 1'b0, 1'b0);
    check_cycle("reset_b", "", 1'b0, 1'b0);
    clear = 1'b0;

    // add R5,R2,R4
    run_instr(32'h1A920000, 1'b0, -1, 1'b0);
    // ld
    run_instr(32'h00800000, 1'b0, -1, 1'b0);
    // br not taken, then taken
    run_instr(32'h98000000, 1'b0, -1, 1'b0);
    run_instr(32'h98000000, 1'b1, -1, 1'b0);
    // st, mul, jal
    run_instr(32'h10000000, 1'b0, -1, 1'b0);
    run_instr(32'h80000000, 1'b0, -1, 1'b0);
    run_instr(32'hA8000000, 1'b0, -1, 1'b0);

    // Random instruction stream (halt excluded) with stray stop pulses.
    for (int n = 0; n < 60; n++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'd27) opc = 5'd26;
      run_instr({opc, 27'($urandom)}, 1'($urandom_range(0, 1)), -1, 1'b1);
    end

    // stop raised at T4 of an add and held: add completes, then HALT.
    run_instr(32'h1A920000, 1'b0, 4, 1'b0);
    expect_halt("stop_halt", 3);
    stop = 1'b0;
    expect_halt("stop_halt_lo", 7);
    clear = 1'b1;
    check_cycle("clr_from_halt", "", 1'b0, 1'b0);
    clear = 1'b0;
    run_instr(32'h30000000, 1'b0, -1, 1'b0);

    // halt opcode
    run_instr(32'hD8000000, 1'b0, -1, 1'b0);
    expect_halt("halt_op", 4);
    clear = 1'b1;
    check_cycle("clr_exit", "", 1'b0, 1'b0);
    clear = 1'b0;
    // Abort fetch at T1: no IRin may follow, fetch restarts at T0.
    check_cycle("abort_T0", "PCout MARin IncPC Zlowin", 1'b0, 1'b1);
    clear = 1'b1;
    check_cycle("abort_T1", "", 1'b0, 1'b0);
    clear = 1'b0;
    run_instr(32'hD0000000, 1'b0, -1, 1'b0);
    run_instr(32'h1A920000, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
